// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between CPU loads/stores and accelerator bursts.
// The CPU has priority, but a starvation limit lets the accelerator win; bursts cannot be preempted.
module dm_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int MAX_BURST = 8,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cpu_re,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_stall,
    input  logic          i_acc_req,
    input  logic          i_acc_we,
    input  logic [3:0]    i_acc_len,
    input  logic [AW-1:0] i_acc_addr,
    input  logic [DW-1:0] i_acc_wdata,
    output logic          o_acc_gnt,
    output logic          o_acc_done,
    output logic          o_acc_rvalid,
    output logic [DW-1:0] o_acc_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_re,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] SL = SW'(STARVE_LIM);
    localparam logic [4:0] MB = 5'(MAX_BURST);
    typedef enum logic {IDLE, BURST} state_t;
    state_t r_state;
    logic [4:0] r_beat_cnt, r_beats;
    logic [SW-1:0] r_starve;
    logic r_dir, r_rvalid;
    logic w_cpu_req, w_acc_win, w_acc_gnt, w_dir, w_last;
    logic [4:0] w_req_beats, w_len_beats;
    assign w_cpu_req   = i_cpu_re | i_cpu_we;
    assign w_req_beats = {1'b0, i_acc_len} + 5'd1;
    assign w_len_beats = (w_req_beats > MB) ? MB : w_req_beats;
    // Reset gates every grant so the memory is quiet even mid-burst.
    assign w_acc_win   = !rst && r_state == IDLE && i_acc_req && (r_starve == SL || !w_cpu_req);
    assign w_acc_gnt   = w_acc_win || (!rst && r_state == BURST);
    assign w_dir       = (r_state == IDLE) ? i_acc_we : r_dir;
    assign w_last      = r_beat_cnt == r_beats - 5'd1;
    assign o_acc_gnt    = w_acc_gnt;
    assign o_acc_done   = w_acc_gnt && ((r_state == IDLE) ? w_len_beats == 5'd1 : w_last);
    assign o_acc_rvalid = r_rvalid;
    assign o_acc_rdata  = i_mem_rdata;
    assign o_cpu_rdata  = i_mem_rdata;
    assign o_cpu_stall  = w_cpu_req && w_acc_gnt;
    assign o_mem_addr   = w_acc_gnt ? i_acc_addr : i_cpu_addr;
    assign o_mem_wdata  = w_acc_gnt ? i_acc_wdata : i_cpu_wdata;
    assign o_mem_re     = w_acc_gnt ? !w_dir : (!rst && i_cpu_re);
    assign o_mem_we     = w_acc_gnt ? w_dir : (!rst && i_cpu_we);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_beats    <= '0;
            r_starve   <= '0;
            r_dir      <= 1'b0;
            r_rvalid   <= 1'b0;
        end else begin
            r_rvalid <= w_acc_gnt && !w_dir;
            r_starve <= w_acc_gnt ? '0 : (i_acc_req && r_starve != SL) ? r_starve + SW'(1) : r_starve;
            if (r_state == IDLE) begin
                if (w_acc_win) begin
                    r_dir   <= i_acc_we;
                    r_beats <= w_len_beats;
                    if (w_len_beats != 5'd1) begin
                        r_state    <= BURST;
                        r_beat_cnt <= 5'd1;
                    end
                end
            end else if (w_last) begin
                r_state    <= IDLE;
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: per-cycle vector table against a small synchronous memory, plus a mid-burst reset sequence.
module tb_dm_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic cpu_re = 0, cpu_we = 0, acc_req = 0, acc_we = 0;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, acc_addr = 0, acc_wdata = 0;
    logic [3:0] acc_len = 0;
    logic [15:0] cpu_rdata, acc_rdata, mem_addr, mem_wdata, mem_rdata;
    logic cpu_stall, acc_gnt, acc_done, acc_rvalid, mem_re, mem_we;
    logic [15:0] mem [256];
    int total = 0, bad = 0;

    dm_arbiter dut (
        .clk(clk), .rst(rst),
        .i_cpu_re(cpu_re), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_acc_req(acc_req), .i_acc_we(acc_we), .i_acc_len(acc_len), .i_acc_addr(acc_addr),
        .i_acc_wdata(acc_wdata), .o_acc_gnt(acc_gnt), .o_acc_done(acc_done),
        .o_acc_rvalid(acc_rvalid), .o_acc_rdata(acc_rdata),
        .o_mem_addr(mem_addr), .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    typedef struct {
        logic cre, cwe;
        logic [15:0] caddr, cwd;
        logic areq, awe;
        logic [3:0] alen;
        logic [15:0] aaddr, awd;
        logic st, g, d, rv, mre, mwe;
        logic [15:0] ma;
        logic cr;
        logic [15:0] rd;
    } vec_t;

    vec_t vt [30];

    function automatic vec_t mk(logic cre, logic cwe, logic [15:0] caddr, logic [15:0] cwd,
                                logic areq, logic awe, logic [3:0] alen, logic [15:0] aaddr,
                                logic [15:0] awd, logic st, logic g, logic d, logic rv,
                                logic mre, logic mwe, logic [15:0] ma, logic cr, logic [15:0] rd);
        vec_t v;
        v.cre = cre; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.areq = areq; v.awe = awe; v.alen = alen; v.aaddr = aaddr; v.awd = awd;
        v.st = st; v.g = g; v.d = d; v.rv = rv; v.mre = mre; v.mwe = mwe; v.ma = ma;
        v.cr = cr; v.rd = rd;
        return v;
    endfunction

    task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        cpu_re = v.cre; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
        acc_req = v.areq; acc_we = v.awe; acc_len = v.alen; acc_addr = v.aaddr; acc_wdata = v.awd;
    endtask

    initial begin
        // CPU stores, then a load of the first address
        vt[0]  = mk(0,1,16'h0010,16'hBEEF, 0,0,0,0,0, 0,0,0,0,0,1,16'h0010, 0,0);
        vt[1]  = mk(0,1,16'h0011,16'h1111, 0,0,0,0,0, 0,0,0,0,0,1,16'h0011, 0,0);
        vt[2]  = mk(0,1,16'h0012,16'h2222, 0,0,0,0,0, 0,0,0,0,0,1,16'h0012, 0,0);
        vt[3]  = mk(0,1,16'h0013,16'h3333, 0,0,0,0,0, 0,0,0,0,0,1,16'h0013, 0,0);
        vt[4]  = mk(1,0,16'h0010,0,        0,0,0,0,0, 0,0,0,0,1,0,16'h0010, 0,0);
        vt[5]  = mk(0,0,16'h0010,0,        0,0,0,0,0, 0,0,0,0,0,0,16'h0010, 1,16'hBEEF);
        // accelerator-only 4-beat read
        vt[6]  = mk(0,0,0,0, 1,0,3,16'h0010,0, 0,1,0,0,1,0,16'h0010, 0,0);
        vt[7]  = mk(0,0,0,0, 0,0,0,16'h0011,0, 0,1,0,1,1,0,16'h0011, 1,16'hBEEF);
        vt[8]  = mk(0,0,0,0, 0,0,0,16'h0012,0, 0,1,0,1,1,0,16'h0012, 1,16'h1111);
        vt[9]  = mk(0,0,0,0, 0,0,0,16'h0013,0, 0,1,1,1,1,0,16'h0013, 1,16'h2222);
        vt[10] = mk(0,0,0,0, 0,0,0,0,0,        0,0,0,1,0,0,16'h0000, 1,16'h3333);
        vt[11] = mk(0,0,0,0, 0,0,0,0,0,        0,0,0,0,0,0,16'h0000, 0,0);
        // contention: CPU keeps loading, accelerator wins after the starvation limit
        for (int i = 12; i < 16; i++)
            vt[i] = mk(1,0,16'h0010,0, 1,1,1,16'h0030,16'hA5A5, 0,0,0,0,1,0,16'h0010, i != 12,16'hBEEF);
        vt[16] = mk(1,0,16'h0010,0, 1,1,1,16'h0030,16'hA5A5, 1,1,0,0,0,1,16'h0030, 1,16'hBEEF);
        vt[17] = mk(1,0,16'h0010,0, 0,1,1,16'h0031,16'hA5A6, 1,1,1,0,0,1,16'h0031, 0,0);
        // burst over: stalled CPU wins first even though acc re-requests
        vt[18] = mk(1,0,16'h0010,0, 1,0,0,16'h0010,0, 0,0,0,0,1,0,16'h0010, 0,0);
        vt[19] = mk(1,0,16'h0030,0, 1,0,0,16'h0010,0, 0,0,0,0,1,0,16'h0030, 1,16'hBEEF);
        vt[20] = mk(0,0,0,0,        1,0,0,16'h0010,0, 0,1,1,0,1,0,16'h0010, 1,16'hA5A5);
        // acc_len=15 saturates to 8 beats
        vt[21] = mk(0,0,0,0, 1,0,15,16'h0010,0, 0,1,0,1,1,0,16'h0010, 1,16'hBEEF);
        for (int i = 22; i < 29; i++)
            vt[i] = mk(0,0,0,0, 0,0,0,16'h0011,0, 0,1,i == 28,1,1,0,16'h0011, 1, i == 22 ? 16'hBEEF : 16'h1111);
        vt[29] = mk(0,0,0,0, 0,0,0,0,0, 0,0,0,1,0,0,16'h0000, 1,16'h1111);

        cpu_re = 1; cpu_addr = 16'h0010; acc_req = 1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst gnt", {15'd0, acc_gnt}, 16'd0);
            chk("rst stall", {15'd0, cpu_stall}, 16'd0);
            chk("rst mem_re", {15'd0, mem_re}, 16'd0);
            chk("rst rvalid", {15'd0, acc_rvalid}, 16'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            apply(vt[i]);
            #1;
            chk($sformatf("v%0d stall", i), {15'd0, cpu_stall}, {15'd0, vt[i].st});
            chk($sformatf("v%0d gnt", i), {15'd0, acc_gnt}, {15'd0, vt[i].g});
            chk($sformatf("v%0d done", i), {15'd0, acc_done}, {15'd0, vt[i].d});
            chk($sformatf("v%0d rvalid", i), {15'd0, acc_rvalid}, {15'd0, vt[i].rv});
            chk($sformatf("v%0d mem_re", i), {15'd0, mem_re}, {15'd0, vt[i].mre});
            chk($sformatf("v%0d mem_we", i), {15'd0, mem_we}, {15'd0, vt[i].mwe});
            chk($sformatf("v%0d mem_addr", i), mem_addr, vt[i].ma);
            if (vt[i].cr) begin
                chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vt[i].rd);
                chk($sformatf("v%0d acc_rdata", i), acc_rdata, vt[i].rd);
            end
            @(negedge clk);
        end

        // reset lands on the third beat of a 6-beat write burst
        cpu_re = 0; acc_req = 1; acc_we = 1; acc_len = 5; acc_addr = 16'h0040; acc_wdata = 16'h0001;
        #1;
        chk("burst b0 gnt", {15'd0, acc_gnt}, 16'd1);
        chk("burst b0 we", {15'd0, mem_we}, 16'd1);
        @(negedge clk);
        acc_req = 0; acc_addr = 16'h0041;
        #1;
        chk("burst b1 gnt", {15'd0, acc_gnt}, 16'd1);
        chk("burst b1 done", {15'd0, acc_done}, 16'd0);
        @(negedge clk);
        rst = 1; acc_addr = 16'h0042;
        #1;
        chk("midrst gnt", {15'd0, acc_gnt}, 16'd0);
        chk("midrst we", {15'd0, mem_we}, 16'd0);
        chk("midrst done", {15'd0, acc_done}, 16'd0);
        @(negedge clk);
        rst = 0; cpu_we = 1; cpu_addr = 16'h0050; cpu_wdata = 16'h5555;
        #1;
        chk("postrst gnt", {15'd0, acc_gnt}, 16'd0);
        chk("postrst done", {15'd0, acc_done}, 16'd0);
        chk("postrst stall", {15'd0, cpu_stall}, 16'd0);
        chk("postrst we", {15'd0, mem_we}, 16'd1);
        chk("postrst addr", mem_addr, 16'h0050);
        @(negedge clk);
        cpu_we = 0;
        #1;
        chk("postrst rvalid", {15'd0, acc_rvalid}, 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
